corescore_stream_arbiter: RTL

//   Packet-level round-robin arbiter sharing one byte-wide AXI-Stream sink (the UART emitter) among NUM_SRC byte-stream sources.

---
 rtl/corescore_stream_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/corescore_stream_arbiter.sv
// Packet-level round-robin arbiter merging NUM_SRC byte streams onto one AXI-Stream sink.
// Define CORESCORE_ARB_TIMEOUT_EN to add the stall timeout with ABORT/DROP recovery.
module corescore_stream_arbiter #(
    parameter int NUM_SRC        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [8*NUM_SRC-1:0]   i_tdata,
    input  logic [NUM_SRC-1:0]     i_tlast,
    input  logic [NUM_SRC-1:0]     i_tvalid,
    output logic [NUM_SRC-1:0]     o_tready,
    output logic [7:0]             o_tdata,
    output logic                   o_tlast,
    output logic                   o_tvalid,
    input  logic                   i_tready,
    output logic [NUM_SRC-1:0]     o_grant,
    output logic                   o_timeout
);

    localparam int IDX_W = $clog2(NUM_SRC);

`ifdef CORESCORE_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ABORT = 2'd2,
        ST_DROP  = 2'd3
    } state_t;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
`else
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;
`endif

    generate
        if (NUM_SRC < 2 || NUM_SRC > 16 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
            $error("corescore_stream_arbiter: NUM_SRC must be 2..16 and TIMEOUT_CYCLES >= 2");
        end
    endgenerate

    state_t             state_r;
    logic [NUM_SRC-1:0] grant_r;
    logic [IDX_W-1:0]   grant_idx_r;
    logic [IDX_W-1:0]   rr_ptr_r;
    logic [IDX_W:0]     win_s;
    logic               xfer_last_s;
`ifdef CORESCORE_ARB_TIMEOUT_EN
    logic [CNT_W-1:0]   stall_cnt_r;
    logic               timeout_r;
`endif

    // Nearest requester above ptr (wrapping); descending scan lets the closest one overwrite.
    function automatic logic [IDX_W:0] pick_winner(input logic [NUM_SRC-1:0] req,
                                                   input logic [IDX_W-1:0]   ptr);
        logic [IDX_W:0] res;
        int             cand;
        res = '0;
        for (int i = NUM_SRC; i >= 1; i--) begin
            cand = (int'(ptr) + i) % NUM_SRC;
            if (req[cand]) begin
                res = {1'b1, IDX_W'(cand)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Round-robin winner and last-beat handshake detection.
    always_comb begin
        win_s       = pick_winner(i_tvalid, rr_ptr_r);
        xfer_last_s = o_tvalid & i_tready & o_tlast;
    end

    // Output steering: granted lanes pass straight through with zero latency.
    always_comb begin
        o_tdata  = 8'h00;
        o_tlast  = 1'b0;
        o_tvalid = 1'b0;
        o_tready = '0;
        case (state_r)
            ST_GRANT: begin
                o_tdata  = i_tdata[{grant_idx_r, 3'b000} +: 8];
                o_tlast  = i_tlast[grant_idx_r];
                o_tvalid = i_tvalid[grant_idx_r];
                o_tready = grant_r & {NUM_SRC{i_tready}};
            end
`ifdef CORESCORE_ARB_TIMEOUT_EN
            ST_ABORT: begin
                o_tdata  = 8'h0A;
                o_tlast  = 1'b1;
                o_tvalid = 1'b1;
                o_tready = '0;
            end
            ST_DROP: begin
                o_tdata  = 8'h00;
                o_tlast  = 1'b0;
                o_tvalid = 1'b0;
                o_tready = grant_r;
            end
`endif
            default: begin
                o_tdata  = 8'h00;
                o_tlast  = 1'b0;
                o_tvalid = 1'b0;
                o_tready = '0;
            end
        endcase
    end

    // Arbitration FSM; grant is released on the edge that moves the tlast beat.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r     <= ST_IDLE;
            grant_r     <= '0;
            grant_idx_r <= '0;
            rr_ptr_r    <= IDX_W'(NUM_SRC - 1);
`ifdef CORESCORE_ARB_TIMEOUT_EN
            stall_cnt_r <= '0;
            timeout_r   <= 1'b0;
`endif
        end else begin
`ifdef CORESCORE_ARB_TIMEOUT_EN
            timeout_r <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (win_s[IDX_W]) begin
                        state_r     <= ST_GRANT;
                        grant_r     <= {{(NUM_SRC-1){1'b0}}, 1'b1} << win_s[IDX_W-1:0];
                        grant_idx_r <= win_s[IDX_W-1:0];
                        rr_ptr_r    <= win_s[IDX_W-1:0];
`ifdef CORESCORE_ARB_TIMEOUT_EN
                        stall_cnt_r <= '0;
`endif
                    end
                end
                ST_GRANT: begin
                    if (xfer_last_s) begin
                        state_r <= ST_IDLE;
                        grant_r <= '0;
                    end
`ifdef CORESCORE_ARB_TIMEOUT_EN
                    else if (!i_tvalid[grant_idx_r]) begin
                        if (stall_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                            state_r     <= ST_ABORT;
                            timeout_r   <= 1'b1;
                            stall_cnt_r <= '0;
                        end else begin
                            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
                        end
                    end else begin
                        stall_cnt_r <= '0;
                    end
`endif
                end
`ifdef CORESCORE_ARB_TIMEOUT_EN
                ST_ABORT: begin
                    if (i_tready) begin
                        state_r <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (i_tvalid[grant_idx_r] && i_tlast[grant_idx_r]) begin
                        state_r <= ST_IDLE;
                        grant_r <= '0;
                    end
                end
`endif
                default: begin
                    state_r <= ST_IDLE;
                    grant_r <= '0;
                end
            endcase
        end
    end

    assign o_grant = grant_r;
`ifdef CORESCORE_ARB_TIMEOUT_EN
    assign o_timeout = timeout_r;
`else
    assign o_timeout = 1'b0;
`endif

endmodule
